// File: rtl/decimal_entry.sv
// Keypad entry: builds a two-digit decimal number from key events and
// exposes live BCD digits, the binary value, and a committed result.
module decimal_entry #(
  parameter logic [3:0] ENTER_KEY = 4'hE,
  parameter logic [3:0] CLEAR_KEY = 4'hC,
  parameter logic [3:0] BKSP_KEY  = 4'hB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] entry_tens,
  output logic [3:0] entry_ones,
  output logic [1:0] entry_count,
  output logic [7:0] entry_value,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [3:0]  tens_r, tens_s;
  logic [3:0]  ones_r, ones_s;
  logic [1:0]  count_r, count_s;
  logic [7:0]  value_r, value_s;
  logic [7:0]  result_r, result_s;
  logic        result_valid_r, result_valid_s;
  logic        err_r, err_s;
  logic [7:0]  tens_wide_s;

  // Next-state decode of the key event; outputs are derived from next digits.
  always_comb begin
    state_s        = state_r;
    tens_s         = tens_r;
    ones_s         = ones_r;
    result_s       = result_r;
    result_valid_s = 1'b0;
    err_s          = 1'b0;
    if (key_valid) begin
      if (key_code <= 4'd9) begin
        case (state_r)
          EMPTY: begin
            ones_s  = key_code;
            tens_s  = 4'd0;
            state_s = ONE;
          end
          ONE: begin
            tens_s  = ones_r;
            ones_s  = key_code;
            state_s = TWO;
          end
          TWO:     err_s = 1'b1;
          default: state_s = EMPTY;
        endcase
      end else if (key_code == BKSP_KEY) begin
        case (state_r)
          TWO: begin
            ones_s  = tens_r;
            tens_s  = 4'd0;
            state_s = ONE;
          end
          ONE: begin
            ones_s  = 4'd0;
            tens_s  = 4'd0;
            state_s = EMPTY;
          end
          EMPTY:   err_s = 1'b1;
          default: state_s = EMPTY;
        endcase
      end else if (key_code == CLEAR_KEY) begin
        tens_s  = 4'd0;
        ones_s  = 4'd0;
        state_s = EMPTY;
      end else if (key_code == ENTER_KEY) begin
        if (state_r == EMPTY) begin
          err_s = 1'b1;
        end else begin
          result_s       = value_r;
          result_valid_s = 1'b1;
          tens_s         = 4'd0;
          ones_s         = 4'd0;
          state_s        = EMPTY;
        end
      end else begin
        state_s = state_r;
      end
    end else begin
      state_s = state_r;
    end

    case (state_s)
      EMPTY:   count_s = 2'd0;
      ONE:     count_s = 2'd1;
      TWO:     count_s = 2'd2;
      default: count_s = 2'd0;
    endcase

    // tens*10 as shift-and-add keeps the multiplier out of the datapath.
    tens_wide_s = {4'd0, tens_s};
    value_s     = (tens_wide_s << 3) + (tens_wide_s << 1) + {4'd0, ones_s};
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= EMPTY;
      tens_r         <= 4'd0;
      ones_r         <= 4'd0;
      count_r        <= 2'd0;
      value_r        <= 8'd0;
      result_r       <= 8'd0;
      result_valid_r <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      state_r        <= state_s;
      tens_r         <= tens_s;
      ones_r         <= ones_s;
      count_r        <= count_s;
      value_r        <= value_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      err_r          <= err_s;
    end
  end

  assign entry_tens   = tens_r;
  assign entry_ones   = ones_r;
  assign entry_count  = count_r;
  assign entry_value  = value_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign err          = err_r;

endmodule
